// File: rtl/sample_arbiter_if.sv
// rtl/sample_arbiter_if.sv - request/grant, result and sample-pin bundle for sample_arbiter
interface sample_arbiter_if #(
  parameter int DATA_BITS = 16
);
  logic                 req_read;
  logic                 req_read_msp;
  logic                 req_bg;
  logic                 req_bg_msp;
  logic                 abort;
  logic                 gnt_read;
  logic                 gnt_bg;
  logic                 busy;
  logic                 sample_owner;
  logic [DATA_BITS-1:0] sample_data;
  logic                 sample_valid;
  logic                 adc_sample_ctl;
  logic                 adc_sample_clk;
  logic                 adc_sample_datain;
  logic                 msp_sample_ctl;
  logic                 msp_sample_clk;
  logic                 msp_sample_datain;

  // arbiter side
  modport slave (
    input  req_read, req_read_msp, req_bg, req_bg_msp, abort,
    input  adc_sample_datain, msp_sample_datain,
    output gnt_read, gnt_bg, busy, sample_owner, sample_data, sample_valid,
    output adc_sample_ctl, adc_sample_clk, msp_sample_ctl, msp_sample_clk
  );

  // requesters and the two serial devices
  modport master (
    output req_read, req_read_msp, req_bg, req_bg_msp, abort,
    output adc_sample_datain, msp_sample_datain,
    input  gnt_read, gnt_bg, busy, sample_owner, sample_data, sample_valid,
    input  adc_sample_ctl, adc_sample_clk, msp_sample_ctl, msp_sample_clk
  );
endinterface

// File: rtl/sample_arbiter.sv
// rtl/sample_arbiter.sv - round-robin owner of the shared ADC/MSP430 serial sample port
module sample_arbiter #(
  parameter int DATA_BITS    = 16,
  parameter int CLK_DIV      = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  sample_arbiter_if.slave bus
);

  localparam int PH_MAX = (CLK_DIV > SETUP_CYCLES) ? CLK_DIV : SETUP_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam int BW     = $clog2(DATA_BITS + 1);

  localparam logic [PW-1:0] DIV_LAST   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] SETUP_LAST = PW'(SETUP_CYCLES - 1);
  localparam logic [BW-1:0] BITS_ALL   = BW'(DATA_BITS);

  typedef enum logic [2:0] {IDLE, SETUP, HI, LO, DONE} state_t;

  state_t               state;
  logic [PW-1:0]        phase;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 owner;       // 0 = read, 1 = bg for the transaction in flight
  logic                 last_owner;  // loser of the next tie
  logic                 sel_msp;     // source latched at grant

  logic                 pick_bg;
  logic                 pick_msp;
  logic                 cancel;
  logic                 din;

  // arbitration: a lone request wins, a tie goes to whoever was not served last
  always_comb begin
    pick_bg  = 1'b0;
    pick_msp = 1'b0;
    pick_bg  = bus.req_bg && (!bus.req_read || !last_owner);
    pick_msp = pick_bg ? bus.req_bg_msp : bus.req_read_msp;
  end

  assign cancel = bus.abort || (owner ? !bus.req_bg : !bus.req_read);
  assign din    = sel_msp ? bus.msp_sample_datain : bus.adc_sample_datain;

  // transaction FSM; every pin and handshake output comes straight from a flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      phase              <= '0;
      bit_cnt            <= '0;
      shreg              <= '0;
      owner              <= 1'b0;
      last_owner         <= 1'b1;
      sel_msp            <= 1'b0;
      bus.gnt_read       <= 1'b0;
      bus.gnt_bg         <= 1'b0;
      bus.busy           <= 1'b0;
      bus.sample_owner   <= 1'b0;
      bus.sample_data    <= '0;
      bus.sample_valid   <= 1'b0;
      bus.adc_sample_ctl <= 1'b0;
      bus.adc_sample_clk <= 1'b0;
      bus.msp_sample_ctl <= 1'b0;
      bus.msp_sample_clk <= 1'b0;
    end else begin
      bus.sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_read || bus.req_bg) begin
            owner              <= pick_bg;
            last_owner         <= pick_bg;
            sel_msp            <= pick_msp;
            bus.gnt_read       <= !pick_bg;
            bus.gnt_bg         <= pick_bg;
            bus.adc_sample_ctl <= !pick_msp;
            bus.msp_sample_ctl <= pick_msp;
            bus.busy           <= 1'b1;
            phase              <= '0;
            bit_cnt            <= '0;
            state              <= SETUP;
          end
        end
        SETUP, HI, LO: begin
          if (cancel) begin
            // drop the port; last_owner keeps the grant just made
            bus.gnt_read       <= 1'b0;
            bus.gnt_bg         <= 1'b0;
            bus.adc_sample_ctl <= 1'b0;
            bus.adc_sample_clk <= 1'b0;
            bus.msp_sample_ctl <= 1'b0;
            bus.msp_sample_clk <= 1'b0;
            bus.busy           <= 1'b0;
            state              <= IDLE;
          end else if (state == SETUP) begin
            if (phase == SETUP_LAST) begin
              phase              <= '0;
              bus.adc_sample_clk <= !sel_msp;
              bus.msp_sample_clk <= sel_msp;
              state              <= HI;
            end else begin
              phase <= phase + 1'b1;
            end
          end else if (state == HI) begin
            if (phase == DIV_LAST) begin
              // capture on the falling sample_clk edge, MSB arrives first
              phase              <= '0;
              shreg              <= (shreg << 1) | DATA_BITS'(din);
              bit_cnt            <= bit_cnt + 1'b1;
              bus.adc_sample_clk <= 1'b0;
              bus.msp_sample_clk <= 1'b0;
              state              <= LO;
            end else begin
              phase <= phase + 1'b1;
            end
          end else begin
            if (phase == DIV_LAST) begin
              phase <= '0;
              if (bit_cnt == BITS_ALL) begin
                bus.gnt_read       <= 1'b0;
                bus.gnt_bg         <= 1'b0;
                bus.adc_sample_ctl <= 1'b0;
                bus.msp_sample_ctl <= 1'b0;
                bus.sample_data    <= shreg;
                bus.sample_owner   <= owner;
                bus.sample_valid   <= 1'b1;
                state              <= DONE;
              end else begin
                bus.adc_sample_clk <= !sel_msp;
                bus.msp_sample_clk <= sel_msp;
                state              <= HI;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_arbiter.sv
// tb/tb_sample_arbiter.sv - directed self-checking bench for sample_arbiter
module tb_sample_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sample_arbiter_if #(.DATA_BITS(16)) bus_a ();
  sample_arbiter_if #(.DATA_BITS(8))  bus_b ();

  sample_arbiter #(.DATA_BITS(16), .CLK_DIV(4), .SETUP_CYCLES(2)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  sample_arbiter #(.DATA_BITS(8), .CLK_DIV(1), .SETUP_CYCLES(2)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // serial device models: restart on ctl rise, advance on sample_clk fall
  logic [15:0] a_adc_word = 16'hA5C3;
  logic [15:0] a_msp_word = 16'h5A96;
  logic [7:0]  b_msp_word = 8'h3C;
  int a_adc_idx = 0;
  int a_msp_idx = 0;
  int b_msp_idx = 0;

  always @(posedge bus_a.adc_sample_ctl) a_adc_idx = 0;
  always @(negedge bus_a.adc_sample_clk) a_adc_idx = a_adc_idx + 1;
  always @(posedge bus_a.msp_sample_ctl) a_msp_idx = 0;
  always @(negedge bus_a.msp_sample_clk) a_msp_idx = a_msp_idx + 1;
  always @(posedge bus_b.msp_sample_ctl) b_msp_idx = 0;
  always @(negedge bus_b.msp_sample_clk) b_msp_idx = b_msp_idx + 1;

  assign bus_a.adc_sample_datain = (a_adc_idx < 16) ? a_adc_word[15 - a_adc_idx] : 1'b0;
  assign bus_a.msp_sample_datain = (a_msp_idx < 16) ? a_msp_word[15 - a_msp_idx] : 1'b0;
  assign bus_b.msp_sample_datain = (b_msp_idx < 8)  ? b_msp_word[7 - b_msp_idx]  : 1'b0;
  assign bus_b.adc_sample_datain = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int  first_rise;
    int  msp_seen;
    int  valid_early;
    int  toggles;
    logic prev_clk;

    bus_a.req_read = 1'b0; bus_a.req_read_msp = 1'b0;
    bus_a.req_bg   = 1'b0; bus_a.req_bg_msp   = 1'b0; bus_a.abort = 1'b0;
    bus_b.req_read = 1'b0; bus_b.req_read_msp = 1'b0;
    bus_b.req_bg   = 1'b0; bus_b.req_bg_msp   = 1'b0; bus_b.abort = 1'b0;

    // reset state
    tick(2);
    reset = 1'b0;
    #1;
    check("rst_gnt", {bus_a.gnt_read, bus_a.gnt_bg}, 2'b00);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_pins", {bus_a.adc_sample_ctl, bus_a.adc_sample_clk, bus_a.msp_sample_ctl, bus_a.msp_sample_clk}, 4'h0);
    check("rst_data", bus_a.sample_data, 16'h0000);
    check("rst_valid", bus_a.sample_valid, 1'b0);

    // read only, ADC
    bus_a.req_read = 1'b1;
    tick(1);
    check("t1_gnt_read", bus_a.gnt_read, 1'b1);
    check("t1_adc_ctl", bus_a.adc_sample_ctl, 1'b1);
    check("t1_busy", bus_a.busy, 1'b1);
    first_rise = 0; msp_seen = 0; valid_early = 0;
    for (int e = 2; e <= 130; e++) begin
      tick(1);
      if (bus_a.adc_sample_clk && first_rise == 0) first_rise = e;
      if (bus_a.msp_sample_ctl || bus_a.msp_sample_clk) msp_seen++;
      if (bus_a.sample_valid) valid_early++;
    end
    tick(1);
    check("t1_first_rise", first_rise, 3);
    check("t1_msp_quiet", msp_seen, 0);
    check("t1_no_early_valid", valid_early, 0);
    check("t1_valid", bus_a.sample_valid, 1'b1);
    check("t1_data", bus_a.sample_data, 16'hA5C3);
    check("t1_owner", bus_a.sample_owner, 1'b0);
    check("t1_done_pins", {bus_a.gnt_read, bus_a.adc_sample_ctl, bus_a.adc_sample_clk}, 3'b000);
    bus_a.req_read = 1'b0;
    tick(1);
    check("t1_valid_pulse", bus_a.sample_valid, 1'b0);
    check("t1_idle", bus_a.busy, 1'b0);

    // tie after reset: read first, then bg on MSP
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    bus_a.req_read = 1'b1; bus_a.req_read_msp = 1'b0;
    bus_a.req_bg   = 1'b1; bus_a.req_bg_msp   = 1'b1;
    tick(1);
    check("t2_tie_read", {bus_a.gnt_read, bus_a.gnt_bg}, 2'b10);
    tick(130);
    check("t2_read_valid", {bus_a.sample_valid, bus_a.sample_owner}, 2'b10);
    check("t2_read_data", bus_a.sample_data, 16'hA5C3);
    bus_a.req_read = 1'b0;
    tick(1);
    check("t2_idle_gap", {bus_a.gnt_bg, bus_a.msp_sample_ctl}, 2'b00);
    tick(1);
    check("t2_bg_gnt", {bus_a.gnt_read, bus_a.gnt_bg}, 2'b01);
    check("t2_bg_ctl", {bus_a.msp_sample_ctl, bus_a.adc_sample_ctl}, 2'b10);
    tick(130);
    check("t2_bg_valid", {bus_a.sample_valid, bus_a.sample_owner}, 2'b11);
    check("t2_bg_data", bus_a.sample_data, 16'h5A96);

    // alternation with bg held and read re-requesting
    bus_a.req_read = 1'b1;
    tick(2);
    check("t3_alt1_read", {bus_a.gnt_read, bus_a.gnt_bg}, 2'b10);
    tick(130);
    check("t3_alt1_valid", {bus_a.sample_valid, bus_a.sample_owner}, 2'b10);
    tick(2);
    check("t3_alt2_bg", {bus_a.gnt_read, bus_a.gnt_bg}, 2'b01);
    tick(130);
    check("t3_alt2_valid", {bus_a.sample_valid, bus_a.sample_owner}, 2'b11);
    tick(2);
    check("t3_alt3_read", {bus_a.gnt_read, bus_a.gnt_bg}, 2'b10);

    // abort during the 6th HI phase
    tick(43);
    check("t4_in_hi", bus_a.adc_sample_clk, 1'b1);
    bus_a.abort = 1'b1;
    tick(1);
    bus_a.abort = 1'b0;
    check("t4_abort_pins", {bus_a.gnt_read, bus_a.adc_sample_ctl, bus_a.adc_sample_clk, bus_a.busy}, 4'h0);
    check("t4_abort_novalid", bus_a.sample_valid, 1'b0);
    check("t4_abort_data", bus_a.sample_data, 16'h5A96);
    tick(1);
    check("t4_regrant_bg", {bus_a.gnt_read, bus_a.gnt_bg, bus_a.msp_sample_ctl}, 3'b011);

    // granted requester drops its request
    tick(5);
    bus_a.req_bg = 1'b0;
    tick(1);
    check("t4_drop_cancel", {bus_a.gnt_bg, bus_a.msp_sample_ctl, bus_a.msp_sample_clk}, 3'b000);

    // async reset mid-LO
    tick(1);
    check("t5_read_gnt", bus_a.gnt_read, 1'b1);
    tick(7);
    check("t5_in_lo", {bus_a.adc_sample_clk, bus_a.busy}, 2'b01);
    bus_a.req_bg = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_pins", {bus_a.gnt_read, bus_a.gnt_bg, bus_a.adc_sample_ctl, bus_a.busy}, 4'h0);
    check("t5_async_data", bus_a.sample_data, 16'h0000);
    reset = 1'b0;
    tick(1);
    check("t5_tie_read", {bus_a.gnt_read, bus_a.gnt_bg}, 2'b10);
    bus_a.req_read = 1'b0;
    bus_a.req_bg   = 1'b0;
    tick(2);

    // DATA_BITS=8, CLK_DIV=1 on the MSP side
    bus_b.req_read = 1'b1; bus_b.req_read_msp = 1'b1;
    tick(1);
    check("t6_gnt", {bus_b.gnt_read, bus_b.msp_sample_ctl, bus_b.adc_sample_ctl}, 3'b110);
    toggles = 0; prev_clk = 1'b0;
    for (int e = 2; e <= 18; e++) begin
      tick(1);
      if (bus_b.msp_sample_clk !== prev_clk) toggles++;
      prev_clk = bus_b.msp_sample_clk;
    end
    tick(1);
    check("t6_toggles", toggles, 16);
    check("t6_valid", {bus_b.sample_valid, bus_b.sample_owner}, 2'b10);
    check("t6_data", bus_b.sample_data, 8'h3C);
    bus_b.req_read = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
